// File: rtl/uart_alu_pkg.sv
// Shared definitions for the uart_alu packet controller: opcodes, FSM states, header widths.
package uart_alu_pkg;

    localparam int LEN_W = 16;

    localparam logic [7:0] OP_ECHO  = 8'hEC;
    localparam logic [7:0] OP_ADD32 = 8'hA0;
    localparam logic [7:0] OP_XOR32 = 8'hA1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RSVD,
        ST_LEN_LO,
        ST_LEN_HI,
        ST_PAYLOAD,
        ST_RESP,
        ST_DISCARD
    } state_e;

    function automatic logic op_is_alu(input logic [7:0] op);
        return (op == OP_ADD32) || (op == OP_XOR32);
    endfunction

endpackage

// File: rtl/byte_fifo.sv
// Synchronous FIFO with full/empty flags; a push into a full FIFO succeeds when a pop frees the slot.
module byte_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             clr_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] din_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] dout_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_q, wr_d, rd_q, rd_d;
    logic             do_push, do_pop;

    // Pointers carry one extra wrap bit to tell full from empty.
    assign empty_o = (wr_q == rd_q);
    assign full_o  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);
    assign dout_o  = mem_q[rd_q[AW-1:0]];

    always_comb begin
        wr_d = wr_q + (AW+1)'(do_push);
        rd_d = rd_q + (AW+1)'(do_pop);
        if (clr_i) begin
            wr_d = '0;
            rd_d = '0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            wr_q <= wr_d;
            rd_q <= rd_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_q[AW-1:0]] <= din_i;
    end

endmodule

// File: rtl/uart_alu_ctrl.sv
// Packet controller between UART byte streams and the echo / 32-bit ALU datapath.
// Optional mid-packet idle timeout enabled by defining UART_ALU_CTRL_TIMEOUT_EN.
module uart_alu_ctrl
    import uart_alu_pkg::*;
#(
    parameter int FIFO_DEPTH     = 16,
    parameter int TIMEOUT_CYCLES = 13890
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [7:0] rx_data_i,
    input  logic       rx_valid_i,
    output logic [7:0] tx_data_o,
    output logic       tx_valid_o,
    input  logic       tx_ready_i,
    output logic       busy_o,
    output logic       err_o,
    output logic       ovf_o
);

    state_e           state_q, state_d;
    logic [7:0]       op_q, op_d, len_lo_q, len_lo_d;
    logic [LEN_W-1:0] cnt_q, cnt_d, len_w;
    logic [23:0]      word_q, word_d;
    logic [1:0]       bidx_q, bidx_d, ridx_q, ridx_d;
    logic [31:0]      acc_q, acc_d;
    logic             err_q, err_d, ovf_q, ovf_d;
    logic             timeout, is_echo, is_alu, hdr_bad;
    logic             fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [7:0]       fifo_dout;

    assign len_w     = {rx_data_i, len_lo_q};
    assign is_echo   = (op_q == OP_ECHO);
    assign is_alu    = op_is_alu(op_q);
    assign hdr_bad   = !(is_echo || is_alu) || (is_alu && len_w[1:0] != 2'b00);
    assign fifo_push = (state_q == ST_PAYLOAD) && is_echo && rx_valid_i && (cnt_q != '0);
    // The FIFO only holds data while an echo is in flight, never during RESP.
    assign fifo_pop  = !fifo_empty && tx_ready_i;

    byte_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_echo_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .clr_i   (timeout),
        .push_i  (fifo_push),
        .din_i   (rx_data_i),
        .pop_i   (fifo_pop),
        .dout_o  (fifo_dout),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

`ifdef UART_ALU_CTRL_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TO_W-1:0] to_q, to_d;
    logic            timed;

    assign timed   = state_q inside {ST_RSVD, ST_LEN_LO, ST_LEN_HI, ST_PAYLOAD, ST_DISCARD};
    assign to_d    = (!timed || rx_valid_i) ? '0 : to_q + 1'b1;
    assign timeout = timed && !rx_valid_i && (to_q == TO_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) to_q <= '0;
        else        to_q <= to_d;
    end
`else
    assign timeout = 1'b0;
`endif

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (rx_valid_i) state_d = ST_RSVD;
            ST_RSVD:   if (rx_valid_i) state_d = ST_LEN_LO;
            ST_LEN_LO: if (rx_valid_i) state_d = ST_LEN_HI;
            ST_LEN_HI: if (rx_valid_i) begin
                if (len_w == '0)  state_d = ST_IDLE;
                else if (hdr_bad) state_d = ST_DISCARD;
                else              state_d = ST_PAYLOAD;
            end
            ST_PAYLOAD: begin
                if (is_echo) begin
                    if (cnt_q == '0 && fifo_empty) state_d = ST_IDLE;
                end else if (rx_valid_i && cnt_q == LEN_W'(1)) begin
                    state_d = ST_RESP;
                end
            end
            ST_RESP:    if (tx_ready_i && ridx_q == 2'd3) state_d = ST_IDLE;
            ST_DISCARD: if (rx_valid_i && cnt_q == LEN_W'(1)) state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
        if (timeout) state_d = ST_IDLE;
    end

    always_comb begin
        op_d     = op_q;
        len_lo_d = len_lo_q;
        cnt_d    = cnt_q;
        word_d   = word_q;
        bidx_d   = bidx_q;
        acc_d    = acc_q;
        ridx_d   = ridx_q;
        err_d    = 1'b0;
        ovf_d    = ovf_q | (fifo_push && fifo_full && !fifo_pop);
        if (rx_valid_i) begin
            case (state_q)
                ST_IDLE:   op_d = rx_data_i;
                ST_LEN_LO: len_lo_d = rx_data_i;
                ST_LEN_HI: begin
                    cnt_d  = len_w;
                    acc_d  = '0;
                    bidx_d = '0;
                    err_d  = (len_w == '0) ? !is_echo : hdr_bad;
                end
                ST_PAYLOAD, ST_DISCARD: if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                    if (state_q == ST_PAYLOAD && is_alu) begin
                        bidx_d = bidx_q + 1'b1;
                        // Little-endian: the fourth byte completes the word.
                        if (bidx_q == 2'd3)
                            acc_d = (op_q == OP_ADD32) ? acc_q + {rx_data_i, word_q}
                                                       : acc_q ^ {rx_data_i, word_q};
                        else
                            word_d[{bidx_q, 3'b000} +: 8] = rx_data_i;
                    end
                end
                ST_RESP: err_d = 1'b1;
                default: ;
            endcase
        end
        if (state_q == ST_RESP && tx_ready_i) ridx_d = ridx_q + 1'b1;
        if (timeout) begin
            acc_d  = '0;
            bidx_d = '0;
            ridx_d = '0;
            err_d  = 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            op_q     <= '0;
            len_lo_q <= '0;
            cnt_q    <= '0;
            word_q   <= '0;
            bidx_q   <= '0;
            acc_q    <= '0;
            ridx_q   <= '0;
            err_q    <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            op_q     <= op_d;
            len_lo_q <= len_lo_d;
            cnt_q    <= cnt_d;
            word_q   <= word_d;
            bidx_q   <= bidx_d;
            acc_q    <= acc_d;
            ridx_q   <= ridx_d;
            err_q    <= err_d;
            ovf_q    <= ovf_d;
        end
    end

    always_comb begin
        tx_valid_o = 1'b0;
        tx_data_o  = '0;
        busy_o     = (state_q != ST_IDLE);
        if (state_q == ST_RESP) begin
            tx_valid_o = 1'b1;
            tx_data_o  = acc_q[{ridx_q, 3'b000} +: 8];
        end else if (!fifo_empty) begin
            tx_valid_o = 1'b1;
            tx_data_o  = fifo_dout;
        end
    end

    assign err_o = err_q;
    assign ovf_o = ovf_q;

endmodule

// File: tb/tb_uart_alu_ctrl.sv
// Self-checking bench for uart_alu_ctrl: vector table, hand-written corner sequences, random packets vs model.
module tb_uart_alu_ctrl;

    localparam int DEPTH = 16;
    localparam int TO    = 13890;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] rx_data = '0;
    logic       rx_valid = 1'b0;
    logic       tx_ready = 1'b1;
    logic [7:0] tx_data;
    logic       tx_valid, busy, err, ovf;

    int         n_cmp = 0;
    int         n_bad = 0;
    int         errs = 0;
    logic [7:0] cap[$];
    logic       rnd_rdy = 1'b0;
    logic       stall_q = 1'b0;
    logic [7:0] stall_dat = '0;

    always #5 clk = ~clk;

    uart_alu_ctrl #(.FIFO_DEPTH(DEPTH), .TIMEOUT_CYCLES(TO)) dut (
        .clk_i      (clk),
        .rst_i      (rst_n),
        .rx_data_i  (rx_data),
        .rx_valid_i (rx_valid),
        .tx_data_o  (tx_data),
        .tx_valid_o (tx_valid),
        .tx_ready_i (tx_ready),
        .busy_o     (busy),
        .err_o      (err),
        .ovf_o      (ovf)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Passive monitor: records accepted bytes, counts err pulses, checks hold-while-stalled.
    always @(negedge clk) begin
        if (rst_n) begin
            if (err) errs++;
            if (stall_q) begin
                check("tx_hold_valid", {31'd0, tx_valid}, 32'd1);
                check("tx_hold_data", {24'd0, tx_data}, {24'd0, stall_dat});
            end
            if (tx_valid && tx_ready) cap.push_back(tx_data);
            stall_q   = tx_valid && !tx_ready;
            stall_dat = tx_data;
        end else begin
            stall_q = 1'b0;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        if (rnd_rdy) tx_ready = 1'($urandom_range(0, 1));
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        tick();
        rx_valid = 1'b0;
        tick();
        tick();
    endtask

    task automatic wait_idle(input string name);
        int k;
        k = 0;
        while ((busy || tx_valid) && k < 3000) begin
            tick();
            k++;
        end
        check(name, {31'd0, k < 3000}, 32'd1);
        repeat (3) tick();
    endtask

    function automatic void model(input logic [7:0] p[$], output logic [7:0] e[$], output int ne);
        logic [15:0] len;
        logic [31:0] acc, w;
        len = {p[3], p[2]};
        acc = '0;
        e   = {};
        ne  = 0;
        if (p[0] == 8'hEC) begin
            for (int i = 0; i < int'(len); i++) e.push_back(p[4+i]);
        end else if (p[0] == 8'hA0 || p[0] == 8'hA1) begin
            if (len == 0 || len % 4 != 0) ne = 1;
            else begin
                for (int i = 0; i < int'(len); i += 4) begin
                    w   = {p[7+i], p[6+i], p[5+i], p[4+i]};
                    acc = (p[0] == 8'hA0) ? acc + w : acc ^ w;
                end
                for (int i = 0; i < 4; i++) e.push_back(acc[8*i +: 8]);
            end
        end else begin
            ne = 1;
        end
    endfunction

    typedef struct {
        string      name;
        int         plen;
        logic [7:0] pkt [12];
        int         nexp;
        logic [7:0] exp [4];
        int         nerr;
    } vec_t;

    vec_t tbl [10];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int e0;
        logic [7:0] pq[$];
        logic [7:0] eq[$];
        int ne, len, r;
        logic [7:0] op;

        tbl[0] = '{"echo3", 7, '{8'hEC,8'h00,8'h03,8'h00,8'h41,8'h42,8'h43,0,0,0,0,0}, 3, '{8'h41,8'h42,8'h43,0}, 0};
        tbl[1] = '{"add_wrap", 12, '{8'hA0,8'h00,8'h08,8'h00,8'h01,8'h00,8'h00,8'h00,8'hFF,8'hFF,8'hFF,8'hFF}, 4, '{8'h00,8'h00,8'h00,8'h00}, 0};
        tbl[2] = '{"xor", 12, '{8'hA1,8'h00,8'h08,8'h00,8'h0F,8'h0F,8'h0F,8'h0F,8'hF0,8'hF0,8'hF0,8'hF0}, 4, '{8'hFF,8'hFF,8'hFF,8'hFF}, 0};
        tbl[3] = '{"xor_badlen", 7, '{8'hA1,8'h00,8'h03,8'h00,8'h11,8'h22,8'h33,0,0,0,0,0}, 0, '{0,0,0,0}, 1};
        tbl[4] = '{"echo_after_bad", 5, '{8'hEC,8'h00,8'h01,8'h00,8'h77,0,0,0,0,0,0,0}, 1, '{8'h77,0,0,0}, 0};
        tbl[5] = '{"unknown_op", 6, '{8'h55,8'h00,8'h02,8'h00,8'hAA,8'hBB,0,0,0,0,0,0}, 0, '{0,0,0,0}, 1};
        tbl[6] = '{"echo_5a", 5, '{8'hEC,8'h00,8'h01,8'h00,8'h5A,0,0,0,0,0,0,0}, 1, '{8'h5A,0,0,0}, 0};
        tbl[7] = '{"add_len0", 4, '{8'hA0,8'h00,8'h00,8'h00,0,0,0,0,0,0,0,0}, 0, '{0,0,0,0}, 1};
        tbl[8] = '{"echo_len0", 4, '{8'hEC,8'h00,8'h00,8'h00,0,0,0,0,0,0,0,0}, 0, '{0,0,0,0}, 0};
        tbl[9] = '{"add_2words", 12, '{8'hA0,8'h00,8'h08,8'h00,8'h78,8'h56,8'h34,8'h12,8'h11,8'h11,8'h11,8'h11}, 4, '{8'h89,8'h67,8'h45,8'h23}, 0};

        // Reset state
        repeat (3) tick();
        check("rst_busy", {31'd0, busy}, 0);
        check("rst_txv", {31'd0, tx_valid}, 0);
        check("rst_txd", {24'd0, tx_data}, 0);
        check("rst_err", {31'd0, err}, 0);
        check("rst_ovf", {31'd0, ovf}, 0);
        rst_n = 1'b1;
        repeat (2) tick();

        // Table vectors
        for (int v = 0; v < 10; v++) begin
            cap.delete();
            e0 = errs;
            for (int i = 0; i < tbl[v].plen; i++) send_byte(tbl[v].pkt[i]);
            wait_idle({tbl[v].name, "_idle"});
            check({tbl[v].name, "_count"}, cap.size(), tbl[v].nexp);
            for (int i = 0; i < tbl[v].nexp; i++)
                if (i < cap.size()) check({tbl[v].name, "_byte"}, {24'd0, cap[i]}, {24'd0, tbl[v].exp[i]});
            check({tbl[v].name, "_errs"}, errs - e0, tbl[v].nerr);
        end

        // ADD32 response held off by the transmitter: latency, then stable hold
        cap.delete();
        tx_ready = 1'b0;
        send_byte(8'hA0); send_byte(8'h00); send_byte(8'h04); send_byte(8'h00);
        send_byte(8'h04); send_byte(8'h03); send_byte(8'h02);
        rx_data  = 8'h01;
        rx_valid = 1'b1;
        tick();
        rx_valid = 1'b0;
        check("resp_latency_valid", {31'd0, tx_valid}, 1);
        check("resp_latency_data", {24'd0, tx_data}, 32'h04);
        repeat (50) tick();
        check("stall_no_accept", cap.size(), 0);
        tx_ready = 1'b1;
        wait_idle("stall_idle");
        check("stall_count", cap.size(), 4);
        for (int i = 0; i < 4 && i < cap.size(); i++)
            check("stall_byte", {24'd0, cap[i]}, 32'(4 - i));

        // Echo overflow with the transmitter blocked
        cap.delete();
        tx_ready = 1'b0;
        send_byte(8'hEC); send_byte(8'h00); send_byte(8'd20); send_byte(8'h00);
        for (int i = 0; i < 20; i++) begin
            send_byte(8'(8'h10 + i));
            if (i == 15) check("ovf_at_16", {31'd0, ovf}, 0);
            if (i == 16) check("ovf_at_17", {31'd0, ovf}, 1);
        end
        tx_ready = 1'b1;
        wait_idle("ovf_idle");
        check("ovf_count", cap.size(), 16);
        for (int i = 0; i < 16 && i < cap.size(); i++)
            check("ovf_byte", {24'd0, cap[i]}, 32'(8'h10 + i));
        check("ovf_sticky", {31'd0, ovf}, 1);

        // Random packets against the model, with random transmitter backpressure
        rnd_rdy = 1'b1;
        for (int n = 0; n < 30; n++) begin
            r = $urandom_range(0, 3);
            op = (r == 0) ? 8'hEC : (r == 1) ? 8'hA0 : (r == 2) ? 8'hA1 : 8'($urandom_range(0, 255));
            if (op == 8'hEC) len = $urandom_range(0, 12);
            else if (op == 8'hA0 || op == 8'hA1)
                len = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 7) : 4 * $urandom_range(0, 3);
            else len = $urandom_range(0, 6);
            pq = {op, 8'($urandom_range(0, 255)), 8'(len), 8'h00};
            for (int i = 0; i < len; i++) pq.push_back(8'($urandom_range(0, 255)));
            model(pq, eq, ne);
            cap.delete();
            e0 = errs;
            foreach (pq[i]) send_byte(pq[i]);
            wait_idle("rnd_idle");
            check("rnd_count", cap.size(), eq.size());
            for (int i = 0; i < eq.size() && i < cap.size(); i++)
                check("rnd_byte", {24'd0, cap[i]}, {24'd0, eq[i]});
            check("rnd_errs", errs - e0, ne);
        end
        rnd_rdy  = 1'b0;
        tx_ready = 1'b1;

        // Reset in the middle of an ADD32 payload
        send_byte(8'hA0); send_byte(8'h00); send_byte(8'h08); send_byte(8'h00);
        send_byte(8'h01); send_byte(8'h02);
        check("pre_rst_busy", {31'd0, busy}, 1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_busy", {31'd0, busy}, 0);
        check("mid_rst_txv", {31'd0, tx_valid}, 0);
        check("mid_rst_txd", {24'd0, tx_data}, 0);
        check("mid_rst_err", {31'd0, err}, 0);
        check("mid_rst_ovf", {31'd0, ovf}, 0);
        #4;
        rst_n = 1'b1;
        tick();
        cap.delete();
        send_byte(8'hEC); send_byte(8'h00); send_byte(8'h01); send_byte(8'h00); send_byte(8'hC3);
        wait_idle("post_rst_idle");
        check("post_rst_count", cap.size(), 1);
        if (cap.size() > 0) check("post_rst_byte", {24'd0, cap[0]}, 32'hC3);

`ifdef UART_ALU_CTRL_TIMEOUT_EN
        // Header stalls in LEN_HI until the idle timeout fires
        e0 = errs;
        send_byte(8'hA0); send_byte(8'h00); send_byte(8'h08);
        repeat (TO - 20) tick();
        check("to_still_busy", {31'd0, busy}, 1);
        repeat (40) tick();
        check("to_busy_cleared", {31'd0, busy}, 0);
        check("to_err_pulse", errs - e0, 1);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/uart_alu_ctrl.md
Name: uart_alu_ctrl

Overview:
- Packet controller between the UART receiver/transmitter byte streams and the ALU datapath of the uart_alu top level.
- Parses the inbound packet format: opcode, reserved, length LSB, length MSB, then payload bytes, where length is the payload byte count.
- Sequences the operation (echo or 32-bit arithmetic) and returns response bytes to the transmitter over a ready/valid handshake.
- Target system: 16 MHz clock, 115200 baud, about 1389 clock cycles per UART byte.

Parameters:
- FIFO_DEPTH, 16, echo buffer depth in bytes (power of two, at least 2).
- TIMEOUT_CYCLES, 13890, idle cycles allowed mid-packet before abort (about 10 byte times).

Ports:
- clk_i  in  1  system clock.
- rst_i  in  1  asynchronous, active-low reset.
- rx_data_i  in  8  byte from the UART receiver.
- rx_valid_i  in  1  one-cycle strobe per received byte; no backpressure is possible.
- tx_data_o  out  8  byte to the UART transmitter.
- tx_valid_o  out  1  tx_data_o is valid.
- tx_ready_i  in  1  transmitter accepts the byte.
- busy_o  out  1  a packet is in progress (state is not IDLE).
- err_o  out  1  one-cycle pulse on a protocol error.
- ovf_o  out  1  sticky flag: echo FIFO overflow; cleared only by reset.

Behaviour:
- Reset (rst_i = 0, asynchronous): state IDLE, FIFO empty, accumulator 0. tx_valid_o=0, tx_data_o=0, busy_o=0, err_o=0, ovf_o=0.
- Opcodes (shared package): OP_ECHO=8'hEC, OP_ADD32=8'hA0, OP_XOR32=8'hA1. Any other value is an error.
- FSM states: IDLE, RSVD, LEN_LO, LEN_HI, PAYLOAD, RESP, DISCARD. Only rx_valid_i cycles advance the header states.
- IDLE: byte is latched as the opcode, then go to RSVD. The reserved byte is ignored.
- LEN_LO / LEN_HI: assemble len = {msb, lsb}, 16 bits.
- At LEN_HI, decide the next state:
  - len==0: ECHO returns to IDLE with no response; ADD32/XOR32 pulse err_o and return to IDLE.
  - Unknown opcode, or ADD32/XOR32 with len[1:0]!=0: pulse err_o and go to DISCARD.
  - Otherwise go to PAYLOAD.
- PAYLOAD, ECHO: each byte is pushed into the FIFO. The FIFO drains to tx concurrently.
  - Push while full: byte dropped, ovf_o set.
  - Simultaneous push and pop when full: the pop frees the slot, so the push succeeds.
- PAYLOAD, ADD32/XOR32: bytes assemble little-endian 32-bit words.
  - Each completed word is combined into acc: mod 2^32 sum, or XOR. acc starts at 0.
  - After the last byte, go to RESP.
- RESP (ALU ops): emit acc as 4 bytes, LSB first.
- Remaining-byte counter: 16-bit down-counter loaded with len, decremented per payload byte. Payload ends when it reaches 0.
- ECHO completion: returns to IDLE when the counter is 0 and the FIFO is empty.
- Tx handshake:
  - A byte transfers on a cycle with tx_valid_o && tx_ready_i.
  - tx_data_o is stable while tx_valid_o=1 && !tx_ready_i.
  - tx_valid_o is never withdrawn before acceptance.
  - Response latency: the first response byte is valid 1 cycle after the final payload byte strobe.
- Bytes arriving in RESP (a new packet overlapping the response) are dropped and pulse err_o.
- DISCARD: consume len bytes, then return to IDLE.
- Arithmetic width: 32-bit wrap; the carry is discarded.

Optional Feature:
- Macro: UART_ALU_CTRL_TIMEOUT_EN.
- Defined: a counter runs in RSVD, LEN_LO, LEN_HI, PAYLOAD and DISCARD. It reloads on every rx_valid_i.
  - Reaching TIMEOUT_CYCLES: FSM goes to IDLE, FIFO and accumulator are cleared, err_o pulses, and any partial response is abandoned.
  - RESP is not timed.
- Undefined: no counter; the parser waits indefinitely.

Decomposition:
- Package uart_alu_pkg:
  - opcode localparams.
  - FSM state enum typedef.
  - header field widths (LEN_W=16).
- Sub-module byte_fifo: synchronous FIFO parameterised on width and depth, with full/empty and push/pop, instanced once as the echo buffer.

Test Plan:
1. ECHO: EC 00 03 00 41 42 43 -> tx 41,42,43 in order; busy_o falls after the last accept; err_o never pulses.
2. ADD32: A0 00 08 00 01 00 00 00 FF FF FF FF -> tx 00,00,00,00 (1+FFFFFFFF wraps).
   - Same packet with tx_ready_i held low for 50 cycles -> tx_data_o stable throughout, no byte lost.
3. XOR32: A1 00 08 00 0F 0F 0F 0F F0 F0 F0 F0 -> tx FF,FF,FF,FF. Bad length A1 00 03 00 + 3 bytes -> one err_o pulse, 3 bytes discarded, no tx. The next ECHO packet works.
4. Unknown opcode: 55 00 02 00 AA BB -> err_o pulse, no tx. A following EC 00 01 00 5A -> tx 5A.
5. Back-to-back ECHO of 20 bytes at line rate with tx_ready_i=0 throughout -> first 16 buffered, ovf_o=1 after byte 17. Release ready -> 16 bytes out.
6. Reset asserted mid-PAYLOAD of an ADD32 -> all outputs at reset values immediately. With UART_ALU_CTRL_TIMEOUT_EN: header stalled after LEN_LO for TIMEOUT_CYCLES -> err_o pulse, busy_o=0.
